// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and
// MEM-stage data access, one transaction outstanding, data-first with a fetch starvation bound.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_stall,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic                  dm_done,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                grant_dm;

    // Data wins unless fetch is waiting and data already took MAX grants in a row.
    assign grant_dm = dm_req && (!if_req || (streak_q < STREAK_MAX));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d = REQ;
                    owner_d = OWN_DM;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                    wstrb_d = dm_wstrb;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d  = REQ;
                    owner_d  = OWN_IF;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    streak_d = '0;
                end
            end
            REQ:     if (mem_ready)  state_d = WAIT;
            WAIT:    if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            streak_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = (state_q == REQ) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    // Responses only count in WAIT; stray or post-reset mem_rvalid is dropped here.
    assign if_rvalid = (state_q == WAIT) && mem_rvalid && (owner_q == OWN_IF);
    assign dm_done   = (state_q == WAIT) && mem_rvalid && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_done   ? mem_rdata : '0;

    assign if_stall  = if_req && !if_rvalid;
    assign dm_stall  = dm_req && !dm_done;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus
// hand sequences for backpressure, spurious responses and mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [7:0]  dm_wstrb;
    logic        dm_done;
    logic [63:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MAX_DATA_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic [31:0] dma;
        logic        rdy;
        logic        rv;
        logic [63:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic        e_dmd;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_row(input string tag, input logic ifr, input logic [31:0] ifa,
                            input logic dmr, input logic [31:0] dma, input logic rv,
                            input logic [63:0] rdata, input logic e_req, input logic [31:0] e_addr,
                            input logic e_ifv, input logic e_dmd, input logic e_busy);
        vec_t v;
        v.tag = tag; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dma = dma;
        v.rdy = 1'b1; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_dmd = e_dmd; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    // One full transaction: IDLE grant, REQ accepted at once, n_wait empty WAIT cycles, response.
    task automatic push_txn(input string tag, input logic ifr, input logic [31:0] ifa,
                            input logic dmr, input logic [31:0] dma, input logic is_dm,
                            input int n_wait, input logic [63:0] rdata);
        logic [31:0] a;
        a = is_dm ? dma : ifa;
        push_row({tag, "_idle"}, ifr, ifa, dmr, dma, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        push_row({tag, "_req"},  ifr, ifa, dmr, dma, 1'b0, '0, 1'b1, a, 1'b0, 1'b0, 1'b1);
        for (int w = 0; w < n_wait; w++)
            push_row({tag, "_wait"}, ifr, ifa, dmr, dma, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        push_row({tag, "_done"}, ifr, ifa, dmr, dma, 1'b1, rdata, 1'b0, '0, !is_dm, is_dm, 1'b1);
    endtask

    task automatic push_idle(input string tag);
        push_row(tag, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply(input vec_t v);
        if_req = v.ifr; if_addr = v.ifa;
        dm_req = v.dmr; dm_addr = v.dma; dm_we = 1'b0;
        mem_ready = v.rdy; mem_rvalid = v.rv; mem_rdata = v.rdata;
        @(negedge clock);
        check({v.tag, ".mem_req"},   mem_req,   v.e_req);
        check({v.tag, ".mem_we"},    mem_we,    1'b0);
        if (v.e_req) check({v.tag, ".mem_addr"}, mem_addr, v.e_addr);
        check({v.tag, ".if_rvalid"}, if_rvalid, v.e_ifv);
        check({v.tag, ".dm_done"},   dm_done,   v.e_dmd);
        check({v.tag, ".busy"},      busy,      v.e_busy);
        check({v.tag, ".if_stall"},  if_stall,  v.ifr && !v.e_ifv);
        check({v.tag, ".dm_stall"},  dm_stall,  v.dmr && !v.e_dmd);
        if (v.e_ifv) check({v.tag, ".if_rdata"}, if_rdata, v.rdata);
        if (v.e_dmd) check({v.tag, ".dm_rdata"}, dm_rdata, v.rdata);
        next_cycle();
    endtask

    initial begin
        // Single fetch, response 3 cycles after accept.
        push_txn("fetch", 1'b1, 32'h100, 1'b0, '0, 1'b0, 2, 64'hDEAD);
        push_idle("fetch_after");
        // Contention: DM first, fetch waits through it.
        push_txn("cont_dm", 1'b1, 32'h200, 1'b1, 32'h8000, 1'b1, 0, 64'h55);
        push_txn("cont_if", 1'b1, 32'h200, 1'b0, '0, 1'b0, 0, 64'hAA);
        push_idle("cont_after");
        // Starvation bound: four DM grants, then IF, then DM again.
        for (int i = 0; i < 4; i++)
            push_txn("starve_dm", 1'b1, 32'h300, 1'b1, 32'h10 + 32'(8 * i), 1'b1, 0, 64'(i + 1));
        push_txn("starve_if",   1'b1, 32'h300, 1'b1, 32'h30, 1'b0, 0, 64'hF00D);
        push_txn("starve_dm30", 1'b1, 32'h300, 1'b1, 32'h30, 1'b1, 0, 64'hBEEF);
        push_idle("starve_after");

        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h1234;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
        @(posedge clock);
        @(negedge clock);
        check("rst.mem_req",   mem_req,   1'b0);
        check("rst.mem_addr",  mem_addr,  '0);
        check("rst.busy",      busy,      1'b0);
        check("rst.if_rvalid", if_rvalid, 1'b0);
        check("rst.if_rdata",  if_rdata,  '0);
        check("rst.if_stall",  if_stall,  1'b1);
        check("rst.dm_stall",  dm_stall,  1'b0);
        if_req = 1'b0; mem_rvalid = 1'b0;
        next_cycle();
        reset = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Store held under two cycles of backpressure.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40;
        dm_wdata = 64'h1122334455667788; dm_wstrb = 8'h0F;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clock);
        check("st_idle.busy", busy, 1'b0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 2);
            @(negedge clock);
            check("st_req.mem_req",   mem_req,   1'b1);
            check("st_req.mem_we",    mem_we,    1'b1);
            check("st_req.mem_addr",  mem_addr,  32'h40);
            check("st_req.mem_wdata", mem_wdata, 64'h1122334455667788);
            check("st_req.mem_wstrb", mem_wstrb, 8'h0F);
            check("st_req.dm_done",   dm_done,   1'b0);
            next_cycle();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
        @(negedge clock);
        check("st_ack.dm_done",  dm_done,  1'b1);
        check("st_ack.dm_stall", dm_stall, 1'b0);
        check("st_ack.mem_we",   mem_we,   1'b0);
        next_cycle();
        dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;
        @(negedge clock);
        check("st_after.busy",    busy,    1'b0);
        check("st_after.dm_done", dm_done, 1'b0);
        next_cycle();

        // Spurious responses in IDLE and in REQ before accept.
        mem_rvalid = 1'b1; mem_ready = 1'b0;
        @(negedge clock);
        check("sp_idle.if_rvalid", if_rvalid, 1'b0);
        check("sp_idle.dm_done",   dm_done,   1'b0);
        check("sp_idle.busy",      busy,      1'b0);
        next_cycle();
        if_req = 1'b1; if_addr = 32'h500;
        @(negedge clock);
        check("sp_grant.if_rvalid", if_rvalid, 1'b0);
        next_cycle();
        @(negedge clock);
        check("sp_req0.mem_req",   mem_req,   1'b1);
        check("sp_req0.if_rvalid", if_rvalid, 1'b0);
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clock);
        check("sp_req1.mem_req",   mem_req,   1'b1);
        check("sp_req1.mem_addr",  mem_addr,  32'h500);
        check("sp_req1.if_rvalid", if_rvalid, 1'b0);
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clock);
        check("sp_wait.mem_req", mem_req, 1'b0);
        check("sp_wait.busy",    busy,    1'b1);
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 64'h77;
        @(negedge clock);
        check("sp_done.if_rvalid", if_rvalid, 1'b1);
        check("sp_done.if_rdata",  if_rdata,  64'h77);
        next_cycle();
        if_req = 1'b0; mem_rvalid = 1'b0;
        next_cycle();

        // Reset asserted while a load sits in WAIT.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h9000;
        dm_wdata = 64'hFFFF; dm_wstrb = 8'hFF; mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clock);
        check("rm_wait.busy", busy, 1'b1);
        next_cycle();
        #1;
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        #1;
        check("rm.busy",      busy,      1'b0);
        check("rm.mem_req",   mem_req,   1'b0);
        check("rm.mem_we",    mem_we,    1'b0);
        check("rm.mem_addr",  mem_addr,  '0);
        check("rm.mem_wdata", mem_wdata, '0);
        check("rm.mem_wstrb", mem_wstrb, '0);
        check("rm.dm_done",   dm_done,   1'b0);
        check("rm.dm_rdata",  dm_rdata,  '0);
        check("rm.if_rvalid", if_rvalid, 1'b0);
        check("rm.dm_stall",  dm_stall,  1'b1);
        next_cycle();
        reset = 1'b1; dm_req = 1'b0; mem_rvalid = 1'b0;
        next_cycle();
        mem_rvalid = 1'b1;
        @(negedge clock);
        check("rm_late.dm_done",   dm_done,   1'b0);
        check("rm_late.if_rvalid", if_rvalid, 1'b0);
        check("rm_late.busy",      busy,      1'b0);
        next_cycle();
        mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h600;
        next_cycle();
        @(negedge clock);
        check("rm_fetch.mem_req",  mem_req,  1'b1);
        check("rm_fetch.mem_addr", mem_addr, 32'h600);
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 64'hCAFE;
        @(negedge clock);
        check("rm_fetch.if_rvalid", if_rvalid, 1'b1);
        check("rm_fetch.if_rdata",  if_rdata,  64'hCAFE);
        next_cycle();
        if_req = 1'b0; mem_rvalid = 1'b0;
        @(negedge clock);
        check("rm_fetch_after.busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the MEM-stage data access (DM); one transaction outstanding at a time.
- Sits between the IF/MEM pipeline stages and the memory bus.
- Data access has priority. A streak counter bounds fetch starvation.
- Stall outputs feed the pipeline-enable logic the same way the structural-hazard indication does today.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width (byte strobes are DATA_W/8 wide).
- MAX_DATA_STREAK, 4, consecutive DM grants allowed while IF waits; must be >=1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_rvalid cycle inclusive.
- if_addr  in  ADDR_W  fetch address.
- if_rvalid  out  1  one-cycle fetch completion.
- if_rdata  out  DATA_W  fetch data, valid with if_rvalid.
- if_stall  out  1  if_req && !if_rvalid.
- dm_req  in  1  data request; held until dm_done cycle inclusive.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_wstrb  in  DATA_W/8  store byte enables.
- dm_done  out  1  one-cycle data completion.
- dm_rdata  out  DATA_W  load data, valid with dm_done.
- dm_stall  out  1  dm_req && !dm_done.
- mem_req  out  1  memory command valid.
- mem_we  out  1  store command.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory store data.
- mem_wstrb  out  DATA_W/8  memory byte enables.
- mem_ready  in  1  memory accepts command when mem_req && mem_ready.
- mem_rvalid  in  1  response/ack; for loads and stores; >=1 cycle after accept.
- mem_rdata  in  DATA_W  response data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, REQ, WAIT. Owner register: IF or DM.
- IDLE: arbitration happens only here.
  - Grant DM if dm_req && (!if_req || streak < MAX_DATA_STREAK).
  - Else grant IF if if_req.
  - On grant: latch addr/we/wdata/wstrb (IF: we=0, wstrb=0) and owner; go to REQ.
- REQ: mem_req=1 and mem_* driven from the latched registers, stable under backpressure. On mem_ready go to WAIT.
- WAIT: on mem_rvalid:
  - if owner=IF, if_rvalid=1; if owner=DM, dm_done=1 (combinational, same cycle).
  - if_rdata/dm_rdata = mem_rdata passthrough.
  - Next state IDLE.
- Minimum latency: request in IDLE cycle 0, accept cycle 1, completion cycle 2 (when mem_rvalid arrives in cycle 2).
- Next grant is evaluated in IDLE on the following cycle. A requester's held req in its done cycle is never re-granted.
- mem_we is 1 only in REQ with a DM store. mem_req is 0 in IDLE/WAIT.
- mem_addr/wdata/wstrb always reflect the latched registers.
- mem_rvalid in IDLE or REQ is ignored: no completion pulse, no state change.
- Streak counter, saturating, width clog2(MAX_DATA_STREAK+1):
  - DM grant with if_req=1: +1.
  - DM grant with if_req=0: cleared.
  - IF grant: cleared.
- Reset asserted (any state, including mid-transaction): immediately IDLE, streak=0, latched registers=0. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rvalid, dm_done, busy, and rdata outputs.
- if_stall/dm_stall follow the request inputs combinationally, including during reset.
- An in-flight response arriving after reset release is ignored.
- Simultaneous if_req and dm_req with streak=MAX: IF wins once, then streak=0 so DM wins next.

Test Plan:
- Single fetch:
  - Stimulus: if_req, if_addr=0x100; mem_ready=1; mem_rvalid 3 cycles after accept, mem_rdata=0xDEAD.
  - Response: mem_req high exactly 1 cycle with mem_addr=0x100, mem_we=0; if_rvalid 1 cycle with if_rdata=0xDEAD; if_stall high every cycle before it; busy low afterward.
- Contention:
  - Stimulus: if_req@0x200 and dm_req load@0x8000 in the same cycle; memory fixed latency 1.
  - Response: mem_addr sequence 0x8000 then 0x200; dm_done precedes if_rvalid; if_stall stays high through the DM transaction.
- Starvation bound:
  - Stimulus: MAX_DATA_STREAK=4; if_req held; dm_req re-asserted every IDLE with addrs 0x10,0x18,0x20,0x28,0x30.
  - Response: grants DM x4, then IF, then DM@0x30.
- Store with backpressure:
  - Stimulus: dm_we=1, dm_addr=0x40, dm_wdata=0x1122334455667788, dm_wstrb=0x0F; mem_ready low 2 cycles.
  - Response: mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb stable for 3 REQ cycles; dm_done on the ack cycle; dm_rdata ignored.
- Reset mid-transaction:
  - Stimulus: assert reset in WAIT; release; pulse mem_rvalid one cycle later.
  - Response: all outputs 0 asynchronously; no if_rvalid/dm_done pulse; a subsequent if_req completes normally.
- Spurious response:
  - Stimulus: mem_rvalid=1 in IDLE and during REQ before accept.
  - Response: no completion pulse, no state change, streak unchanged.
